// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared definitions for the fetch sequencer.
// Holds the datapath width, PC alignment mask, FSM state encoding and
// the {pc, instr} queue entry layout used by pc_fetch_ctrl and its queue.
package pc_fetch_ctrl_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } queue_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_instr_queue.sv
// pc_fetch_ctrl_instr_queue: synchronous FIFO for fetched {pc, instr} words.
// The head entry is held in a register so decode sees a flop-driven
// valid/data pair; a push into an empty queue shows up the next cycle.
// Flush has priority and discards any same-cycle push or pop.
module pc_fetch_ctrl_instr_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
  logic [CNT_W-1:0] count_next;
  logic             do_push, do_pop;
  logic             head_valid_next;
  logic [WIDTH-1:0] head_data_next;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Next pointers, occupancy and the entry that will sit at the head next cycle
  always_comb begin
    do_pop          = pop & ~empty & ~flush;
    do_push         = push & (~full | do_pop) & ~flush;
    rd_next         = rd_ptr;
    wr_next         = wr_ptr;
    count_next      = count;
    head_valid_next = 1'b0;
    head_data_next  = head_data;
    if (flush) begin
      rd_next    = '0;
      wr_next    = '0;
      count_next = '0;
    end else begin
      if (do_pop) rd_next = rd_ptr + 1'b1;
      if (do_push) wr_next = wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_next = count + 1'b1;
        2'b01:   count_next = count - 1'b1;
        default: count_next = count;
      endcase
      if (count_next != '0) begin
        head_valid_next = 1'b1;
        head_data_next  = (do_push && (wr_ptr == rd_next)) ? din : mem[rd_next];
      end
    end
  end

  // Pointer, count and registered head state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      rd_ptr     <= rd_next;
      wr_ptr     <= wr_next;
      count      <= count_next;
      head_valid <= head_valid_next;
      head_data  <= head_data_next;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC sequencer feeding the FETCH stage.
// Issues one request at a time, queues returned words with their PC and
// handles branch redirects, including orphaned in-flight requests (DRAIN).
// Optional request watchdog enabled by defining FETCH_TIMEOUT_EN.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH   = 4,
  parameter int PC_STEP = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            f_enable,
  output logic [XLEN-1:0] f_addr,
  input  logic [XLEN-1:0] f_data,
  input  logic            f_ack,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RESET_PC[1:0] != 2'b00 || TIMEOUT < 1)
  begin : g_bad_params
    $error("pc_fetch_ctrl: illegal parameter set");
  end

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next, f_addr_next;
  logic            f_enable_next;
  logic            q_push, q_pop, q_flush, q_full, q_empty;
  logic [CNT_W-1:0] q_count;
  queue_entry_t    push_entry, head_entry;

`ifdef FETCH_TIMEOUT_EN
  localparam int TIMER_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TIMER_W-1:0] timer, timer_next;
  logic               gap, gap_next, err_next;
`endif

  assign push_entry  = '{pc: pc, instr: f_data};
  assign q_pop       = instr_ready & ~q_empty;
  assign q_flush     = redirect_valid;
  assign instr_pc    = head_entry.pc;
  assign instr_data  = head_entry.instr;

  pc_fetch_ctrl_instr_queue #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (q_push),
    .pop        (q_pop),
    .flush      (q_flush),
    .din        (push_entry),
    .full       (q_full),
    .empty      (q_empty),
    .count      (q_count),
    .head_valid (instr_valid),
    .head_data  (head_entry)
  );

  // Next-state, PC and request decode; a redirect overrides everything else
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    f_enable_next = f_enable;
    f_addr_next   = f_addr;
    q_push        = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          pc_next = align_pc(redirect_pc);
        end else if (q_count < CNT_W'(DEPTH)) begin
          state_next    = REQ;
          f_enable_next = 1'b1;
          f_addr_next   = pc;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          pc_next = align_pc(redirect_pc);
          if (f_ack) begin
            state_next    = IDLE;
            f_enable_next = 1'b0;
          end else begin
            state_next = DRAIN;
          end
        end else if (f_ack) begin
          q_push        = ~q_full;
          pc_next       = pc + XLEN'(PC_STEP);
          f_enable_next = 1'b0;
          state_next    = IDLE;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_next = align_pc(redirect_pc);
        if (f_ack) begin
          f_enable_next = 1'b0;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next    = IDLE;
        f_enable_next = 1'b0;
      end
    endcase
`ifdef FETCH_TIMEOUT_EN
    timer_next = '0;
    gap_next   = 1'b0;
    err_next   = fetch_err;
    if (state != IDLE && !f_ack) begin
      if (gap) begin
        f_enable_next = 1'b1;
      end else if (timer == TIMER_W'(TIMEOUT - 1)) begin
        err_next      = 1'b1;
        f_enable_next = 1'b0;
        gap_next      = 1'b1;
      end else begin
        timer_next = timer + 1'b1;
      end
    end
`endif
  end

  // Sequencer state, PC and registered request outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      f_enable <= 1'b0;
      f_addr   <= RESET_PC;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      f_enable <= f_enable_next;
      f_addr   <= f_addr_next;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Watchdog counter, one-cycle re-issue gap and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      gap       <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      timer     <= timer_next;
      gap       <= gap_next;
      fetch_err <= err_next;
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

endmodule
